seg_display_mux: RTL
====================

SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, legal range 1..8, number of multiplexed digits.
REQ-002 SHALL have parameter DIGIT_CYCLES, default 200000, number of CLK cycles per digit slot (>= 2^PWM_BITS).
REQ-003 SHALL have parameter DEAD_CYCLES, default 16, anode-off cycles at the start of each slot for anti-ghosting (< DIGIT_CYCLES).
REQ-004 SHALL have parameter PWM_BITS, default 4, brightness resolution.
REQ-005 CLK  in  1  system clock; all logic on rising edge.
REQ-006 RESET  in  1  synchronous, active-high reset.
REQ-007 DIGITS  in  4*NUM_DIGITS  hex value per digit; DIGITS[4i+3:4i] is digit i, digit 0 rightmost.
REQ-008 DP_IN  in  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-009 BLANK  in  NUM_DIGITS  per-digit force-off, 1 = dark.
REQ-010 LZ_SUPPRESS  in  1  leading-zero suppression enable.
REQ-011 BRIGHTNESS  in  PWM_BITS  duty control.
REQ-012 ENABLE  in  1  display enable; 0 = all dark.
REQ-013 ANODE  out  NUM_DIGITS  active-low digit select; ANODE[i] drives digit i.
REQ-014 CATHODE  out  8  active-low segments {CA,CB,CC,CD,CE,CF,CG,CDP}, bit 7 = CA.
REQ-015 FRAME_TICK  out  1  one-cycle pulse when a new frame snapshot is taken.

Function
REQ-016 SHALL keep slot counter CNT counting 0..DIGIT_CYCLES-1 and digit index IDX; at CNT = DIGIT_CYCLES-1, CNT -> 0 and IDX increments, wrapping NUM_DIGITS-1 -> 0.
REQ-017 SHALL latch DIGITS, DP_IN, BLANK and LZ_SUPPRESS into a frame snapshot on the cycle IDX wraps to 0, and on the first cycle after reset; FRAME_TICK SHALL be 1 in exactly that cycle.
REQ-018 SHALL derive all displayed data from the snapshot only; input changes mid-frame SHALL take effect at the next frame.
REQ-019 SHALL encode standard hex glyphs 0-9, A, b, C, d, E, F with segment on = 0, e.g. 0 -> 0000001x, 8 -> 0000000x, F -> 0111000x (bits CA..CG).
REQ-020 SHALL drive CDP = 0 iff snapshot DP for IDX is 1 and the digit is not dark.
REQ-021 SHALL treat digit i (i >= 1) as leading zero when LZ_SUPPRESS snapshot = 1 and digits i..NUM_DIGITS-1 all equal 0; digit 0 SHALL never be suppressed.
REQ-022 A digit SHALL be dark (ANODE bit 1, CATHODE 8'hFF) when BLANK snapshot bit = 1, or leading zero, or ENABLE = 0.
REQ-023 ANODE[IDX] SHALL be 0 only when not dark, CNT >= DEAD_CYCLES, and PWM condition holds; all other ANODE bits SHALL be 1.
REQ-024 PWM condition: BRIGHTNESS all-ones -> always true; BRIGHTNESS = 0 -> always false; otherwise CNT[PWM_BITS-1:0] < BRIGHTNESS.
REQ-025 ANODE and CATHODE SHALL be registered, reflecting CNT/IDX of the previous cycle (1-cycle latency); at most one ANODE bit SHALL be 0 in any cycle.
REQ-026 ENABLE SHALL be sampled live (not snapshotted); CNT and IDX SHALL keep running while ENABLE = 0.
REQ-027 NUM_DIGITS = 1 SHALL take a snapshot every slot; IDX stays 0.

Reset
REQ-028 RESET = 1 SHALL set CNT = 0, IDX = 0, snapshot = all zero, ANODE all ones, CATHODE = 8'hFF, FRAME_TICK = 0 on the next edge.
REQ-029 RESET asserted mid-slot or mid-frame SHALL abort the scan immediately; no partial slot SHALL complete afterwards.
REQ-030 First cycle after RESET release SHALL be a snapshot cycle (FRAME_TICK = 1) with IDX = 0.

Verification (NUM_DIGITS=4, DIGIT_CYCLES=8, DEAD_CYCLES=1, PWM_BITS=2 unless stated)
REQ-031 DIGITS=16'h1234, BRIGHTNESS=3, ENABLE=1 -> ANODE cycles 1110,1101,1011,0111 every 8 cycles, low on CNT 1..7; CATHODE 4 -> 1001100 on digit 0 slot; FRAME_TICK every 32 cycles.
REQ-032 DIGITS=16'h0050, LZ_SUPPRESS=1 -> digits 3,2 dark (ANODE stays 1, CATHODE FF); digit 1 shows 5, digit 0 shows 0; DIGITS=0 -> only digit 0 lit showing 0.
REQ-033 BRIGHTNESS=1 -> ANODE[IDX] low only when CNT[1:0]=0 and CNT>=1, i.e. CNT=4; BRIGHTNESS=0 -> ANODE all 1 always.
REQ-034 Change DIGITS from 16'h1111 to 16'h2222 while IDX=2 -> digits 2,3 still show 1 this frame; all show 2 after next FRAME_TICK.
REQ-035 DP_IN=4'b0100, BLANK=4'b0001 -> CDP=0 only in digit 2 slot; digit 0 dark; ENABLE=0 for 5 cycles -> ANODE all 1, IDX sequence unchanged after.
REQ-036 RESET for 1 cycle at IDX=3, CNT=5 -> next cycle ANODE=1111, CATHODE=FF; after release FRAME_TICK=1 and digit 0 slot restarts with CNT=0.

Source files
------------

// File: rtl/seg_display_mux.sv
// Time-multiplexed 7-segment display driver.
// Frame snapshot, leading-zero blanking, dead-time and PWM brightness.
module seg_display_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 200000,
    parameter int DEAD_CYCLES  = 16,
    parameter int PWM_BITS     = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [4*NUM_DIGITS-1:0] DIGITS,
    input  logic [NUM_DIGITS-1:0]   DP_IN,
    input  logic [NUM_DIGITS-1:0]   BLANK,
    input  logic                    LZ_SUPPRESS,
    input  logic [PWM_BITS-1:0]     BRIGHTNESS,
    input  logic                    ENABLE,
    output logic [NUM_DIGITS-1:0]   ANODE,
    output logic [7:0]              CATHODE,
    output logic                    FRAME_TICK
);

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] snap_dig;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [NUM_DIGITS-1:0]   snap_blank;
    logic                    snap_lz;

    logic                    frame_start;
    logic [4*NUM_DIGITS-1:0] eff_dig;
    logic [NUM_DIGITS-1:0]   eff_dp;
    logic [NUM_DIGITS-1:0]   eff_blank;
    logic                    eff_lz;
    logic [NUM_DIGITS-1:0]   lz;
    logic                    run;
    logic [3:0]              cur_dig;
    logic                    cur_dp;
    logic                    cur_dark;
    logic                    pwm;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   anode_d;
    logic [7:0]              cathode_d;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] g;
        unique case (d)
            4'h0: g = 7'b0000001;
            4'h1: g = 7'b1001111;
            4'h2: g = 7'b0010010;
            4'h3: g = 7'b0000110;
            4'h4: g = 7'b1001100;
            4'h5: g = 7'b0100100;
            4'h6: g = 7'b0100000;
            4'h7: g = 7'b0001111;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0000100;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b1100000;
            4'hC: g = 7'b0110001;
            4'hD: g = 7'b1000010;
            4'hE: g = 7'b0110000;
            4'hF: g = 7'b0111000;
        endcase
        return g;
    endfunction

    // The snapshot cycle displays the freshly latched inputs, not the stale frame.
    assign frame_start = (cnt == '0) && (idx == '0);
    assign eff_dig     = frame_start ? DIGITS      : snap_dig;
    assign eff_dp      = frame_start ? DP_IN       : snap_dp;
    assign eff_blank   = frame_start ? BLANK       : snap_blank;
    assign eff_lz      = frame_start ? LZ_SUPPRESS : snap_lz;

    always_comb begin
        lz  = '0;
        run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run   = run & (eff_dig[4*i +: 4] == 4'h0);
            lz[i] = eff_lz & run;
        end
    end

    always_comb begin
        cur_dig  = 4'h0;
        cur_dp   = 1'b0;
        cur_dark = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_dig  = eff_dig[4*i +: 4];
                cur_dp   = eff_dp[i];
                cur_dark = eff_blank[i] | lz[i];
            end
        end
        cur_dark = cur_dark | ~ENABLE;
    end

    always_comb begin
        pwm = 1'b0;
        if (BRIGHTNESS == '1)
            pwm = 1'b1;
        else if (BRIGHTNESS != '0)
            pwm = cnt[PWM_BITS-1:0] < BRIGHTNESS;
    end

    assign lit = !cur_dark && (int'(cnt) >= DEAD_CYCLES) && pwm;

    always_comb begin
        anode_d = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (lit && idx == IW'(i))
                anode_d[i] = 1'b0;
        end
        cathode_d = cur_dark ? 8'hFF : {glyph(cur_dig), ~cur_dp};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt        <= '0;
            idx        <= '0;
            snap_dig   <= '0;
            snap_dp    <= '0;
            snap_blank <= '0;
            snap_lz    <= 1'b0;
            ANODE      <= '1;
            CATHODE    <= 8'hFF;
            FRAME_TICK <= 1'b0;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (frame_start) begin
                snap_dig   <= DIGITS;
                snap_dp    <= DP_IN;
                snap_blank <= BLANK;
                snap_lz    <= LZ_SUPPRESS;
            end
            ANODE      <= anode_d;
            CATHODE    <= cathode_d;
            FRAME_TICK <= frame_start;
        end
    end

endmodule
